// File: rtl/nfc_pkg.sv
// nfc_pkg: constants and types shared by the PICC emulator and the
// card-detection front end.
//   - command bytes and the command register address
//   - picc_state_t, the 3-bit PICC state encoding exported on card_state
//   - rsp_plan_t, the response a command resolves to at accept time
package nfc_pkg;

  localparam logic [7:0]  CMD_REQA    = 8'h26;
  localparam logic [7:0]  CMD_WUPA    = 8'h52;
  localparam logic [7:0]  CMD_SEL_CL1 = 8'h93;
  localparam logic [7:0]  CMD_HALT    = 8'h50;
  localparam logic [5:0]  ADDR_CMD    = 6'h09;
  localparam logic [15:0] ATQA_MIFARE = 16'h0004;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_READY  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HALT   = 3'd4
  } picc_state_t;

  typedef enum logic [1:0] {
    RSP_ZERO = 2'd0,
    RSP_ATQA = 2'd1,
    RSP_UID  = 2'd2,
    RSP_SAK  = 2'd3
  } rsp_kind_t;

  // Everything needed to play out a response and commit its side effects
  // on the last byte; captured once at accept.
  typedef struct packed {
    rsp_kind_t   kind;
    logic [2:0]  n_bytes;
    picc_state_t nxt;
    logic        err;
    logic        set_ac;
    logic        clr_ac;
  } rsp_plan_t;

  function automatic logic [7:0] uid_bcc(input logic [31:0] uid);
    return uid[31:24] ^ uid[23:16] ^ uid[15:8] ^ uid[7:0];
  endfunction

endpackage

// File: rtl/nfc_card_emulator.sv
// nfc_card_emulator: ISO14443A-style PICC responder on the register command
// bus. Command writes to ADDR_CMD are decoded at accept; after RESP_LATENCY
// cycles the response bytes stream out one per cycle on nfc_cmd_done /
// nfc_cmd_rdata, and the state change commits with the last byte.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   card_present      card in field (drop aborts everything)
//   card_uid          4-byte UID, sampled at accept
//   nfc_cmd_*         command bus (valid/ready handshake, done strobes)
//   nfc_irq           card-arrival interrupt level
//   card_state        current PICC state (picc_state_t)
//   proto_error       strobe coincident with the done of an illegal command
module nfc_card_emulator
  import nfc_pkg::*;
#(
  parameter int          RESP_LATENCY = 8,
  parameter logic [15:0] ATQA         = ATQA_MIFARE,
  parameter logic [7:0]  SAK          = 8'h08
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_present,
  input  logic [31:0] card_uid,
  input  logic        nfc_cmd_valid,
  output logic        nfc_cmd_ready,
  input  logic        nfc_cmd_write,
  input  logic [5:0]  nfc_cmd_addr,
  input  logic [7:0]  nfc_cmd_wdata,
  output logic [7:0]  nfc_cmd_rdata,
  output logic        nfc_cmd_done,
  output logic        nfc_irq,
  output logic [2:0]  card_state,
  output logic        proto_error
);

  localparam int            LW       = $clog2(RESP_LATENCY + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(RESP_LATENCY - 1);

  picc_state_t   state_q, state_d;
  logic          ac_q, ac_d;
  logic          irq_q, irq_d;
  logic          busy_q, done_q, perr_q;
  logic [7:0]    rdata_q, byte_sel;
  logic [LW-1:0] lat_q;
  logic [2:0]    idx_q;
  logic [31:0]   uid_q;
  rsp_plan_t     plan_q, plan_d;
  logic          accept, emit, last, drained, abort, arrive, clr_irq;

  assign nfc_cmd_ready = (state_q != ST_OFF) && !busy_q;
  assign accept        = nfc_cmd_valid && nfc_cmd_ready;
  assign abort         = !card_present && (state_q != ST_OFF);
  assign arrive        = card_present && (state_q == ST_OFF);
  assign emit          = busy_q && (lat_q == '0) && (idx_q < plan_q.n_bytes);
  assign last          = emit && (idx_q == 3'(plan_q.n_bytes - 3'd1));
  // busy is held one extra cycle past the last done so ready rises after it
  assign drained       = busy_q && (lat_q == '0) && (idx_q == plan_q.n_bytes);

  // Command decode, evaluated against the state at accept.
  always_comb begin
    plan_d  = '{RSP_ZERO, 3'd1, state_q, 1'b0, 1'b0, 1'b0};
    clr_irq = 1'b0;
    if (nfc_cmd_write && nfc_cmd_addr == ADDR_CMD) begin
      clr_irq     = (nfc_cmd_wdata == CMD_REQA) || (nfc_cmd_wdata == CMD_WUPA);
      // illegal unless a legal case below overrides it; HALT is sticky
      plan_d.err  = 1'b1;
      plan_d.nxt  = (state_q == ST_HALT) ? ST_HALT : ST_IDLE;
      case (nfc_cmd_wdata)
        CMD_REQA, CMD_WUPA:
          if (state_q != ST_HALT || nfc_cmd_wdata == CMD_WUPA)
            plan_d = '{RSP_ATQA, 3'd2, ST_READY, 1'b0, 1'b0, 1'b1};
        CMD_SEL_CL1:
          if (state_q == ST_READY)
            plan_d = ac_q ? '{RSP_SAK, 3'd1, ST_ACTIVE, 1'b0, 1'b0, 1'b0}
                          : '{RSP_UID, 3'd5, ST_READY,  1'b0, 1'b1, 1'b0};
        CMD_HALT:
          if (state_q == ST_ACTIVE)
            plan_d = '{RSP_ZERO, 3'd1, ST_HALT, 1'b0, 1'b0, 1'b0};
        default: ;
      endcase
    end
  end

  // PICC state / flag next-state; presence changes override the response.
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    irq_d   = irq_q;
    if (abort) begin
      state_d = ST_OFF;
      ac_d    = 1'b0;
      irq_d   = 1'b0;
    end else if (arrive) begin
      state_d = ST_IDLE;
      irq_d   = 1'b1;
    end else begin
      if (accept && clr_irq) irq_d = 1'b0;
      if (last) begin
        state_d = plan_q.nxt;
        if (plan_q.clr_ac) ac_d = 1'b0;
        if (plan_q.set_ac) ac_d = 1'b1;
      end
    end
  end

  // Response byte mux.
  always_comb begin
    byte_sel = 8'h00;
    unique case (plan_q.kind)
      RSP_ATQA: byte_sel = (idx_q == 3'd0) ? ATQA[15:8] : ATQA[7:0];
      RSP_UID:
        case (idx_q)
          3'd0:    byte_sel = uid_q[31:24];
          3'd1:    byte_sel = uid_q[23:16];
          3'd2:    byte_sel = uid_q[15:8];
          3'd3:    byte_sel = uid_q[7:0];
          default: byte_sel = uid_bcc(uid_q);
        endcase
      RSP_SAK:  byte_sel = SAK;
      default:  byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      ac_q    <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      rdata_q <= 8'h00;
      lat_q   <= '0;
      idx_q   <= '0;
      uid_q   <= '0;
      plan_q  <= '{RSP_ZERO, 3'd0, ST_OFF, 1'b0, 1'b0, 1'b0};
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      irq_q   <= irq_d;
      if (abort) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        perr_q  <= 1'b0;
        rdata_q <= 8'h00;
        lat_q   <= '0;
        idx_q   <= '0;
      end else begin
        done_q <= emit;
        perr_q <= emit && plan_q.err;
        if (emit) rdata_q <= byte_sel;
        if (accept) begin
          busy_q <= 1'b1;
          lat_q  <= LAT_INIT;
          idx_q  <= '0;
          plan_q <= plan_d;
          uid_q  <= card_uid;
        end else begin
          if (busy_q && lat_q != '0) lat_q <= lat_q - LW'(1);
          if (emit) idx_q <= idx_q + 3'd1;
          if (drained) busy_q <= 1'b0;
        end
      end
    end
  end

  assign nfc_cmd_done  = done_q;
  assign nfc_cmd_rdata = rdata_q;
  assign proto_error   = perr_q;
  assign nfc_irq       = irq_q;
  assign card_state    = state_q;

endmodule

// File: tb/tb_nfc_card_emulator.sv
// Bench for nfc_card_emulator: directed protocol flow followed by random
// command traffic, each transaction checked against a transaction-level
// card model (expected byte list, proto error, resulting state and irq).
module tb_nfc_card_emulator;
  import nfc_pkg::*;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_present = 1'b0;
  logic [31:0] card_uid = '0;
  logic        nfc_cmd_valid = 1'b0;
  logic        nfc_cmd_ready;
  logic        nfc_cmd_write = 1'b0;
  logic [5:0]  nfc_cmd_addr = '0;
  logic [7:0]  nfc_cmd_wdata = '0;
  logic [7:0]  nfc_cmd_rdata;
  logic        nfc_cmd_done;
  logic        nfc_irq;
  logic [2:0]  card_state;
  logic        proto_error;

  nfc_card_emulator #(.RESP_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .card_present(card_present), .card_uid(card_uid),
    .nfc_cmd_valid(nfc_cmd_valid), .nfc_cmd_ready(nfc_cmd_ready),
    .nfc_cmd_write(nfc_cmd_write), .nfc_cmd_addr(nfc_cmd_addr),
    .nfc_cmd_wdata(nfc_cmd_wdata), .nfc_cmd_rdata(nfc_cmd_rdata),
    .nfc_cmd_done(nfc_cmd_done), .nfc_irq(nfc_irq), .card_state(card_state),
    .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // card model
  picc_state_t m_st  = ST_OFF;
  bit          m_ac  = 1'b0;
  bit          m_irq = 1'b0;
  logic [7:0]  exp_q[$];
  bit          exp_err;
  logic [7:0]  got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Resolve one accepted access into the bytes the card should answer with.
  task automatic model_cmd(input bit wr, input logic [5:0] addr,
                           input logic [7:0] wd, input logic [31:0] uid);
    logic [7:0] b;
    exp_q.delete();
    exp_err = 1'b0;
    if (!(wr && addr == 6'h09)) begin
      exp_q.push_back(8'h00);
      return;
    end
    if (wd == 8'h26 || wd == 8'h52) m_irq = 1'b0;
    if ((wd == 8'h26 && (m_st == ST_IDLE || m_st == ST_READY || m_st == ST_ACTIVE)) ||
        (wd == 8'h52 && m_st != ST_OFF)) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h04);
      m_st = ST_READY;
      m_ac = 1'b0;
    end else if (wd == 8'h93 && m_st == ST_READY && !m_ac) begin
      b = 8'h00;
      for (int i = 3; i >= 0; i--) begin
        exp_q.push_back(uid[i*8 +: 8]);
        b = b ^ uid[i*8 +: 8];
      end
      exp_q.push_back(b);
      m_ac = 1'b1;
    end else if (wd == 8'h93 && m_st == ST_READY) begin
      exp_q.push_back(8'h08);
      m_st = ST_ACTIVE;
    end else if (wd == 8'h50 && m_st == ST_ACTIVE) begin
      exp_q.push_back(8'h00);
      m_st = ST_HALT;
    end else begin
      exp_q.push_back(8'h00);
      exp_err = 1'b1;
      if (m_st != ST_HALT) m_st = ST_IDLE;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_state"}, 32'(card_state), 32'(m_st));
    chk({tag, "_irq"}, 32'(nfc_irq), 32'(m_irq));
  endtask

  task automatic present_on();
    chk("irq_pre_rise", 32'(nfc_irq), 32'(0));
    card_present = 1'b1;
    tick();
    m_st = ST_IDLE; m_irq = 1'b1; m_ac = 1'b0;
    check_state("rise");
  endtask

  task automatic present_off();
    card_present = 1'b0;
    tick();
    m_st = ST_OFF; m_irq = 1'b0; m_ac = 1'b0;
    check_state("fall");
    chk("fall_ready", 32'(nfc_cmd_ready), 32'(0));
  endtask

  // Waits for ready, issues one access and returns with the accept edge
  // just behind (1 time unit past it).
  task automatic issue(input bit wr, input logic [5:0] addr, input logic [7:0] wd,
                       input logic [31:0] uid, output bit ok);
    int n = 0;
    while (!nfc_cmd_ready && n < 50) begin tick(); n++; end
    ok = nfc_cmd_ready;
    if (!ok) begin
      chk("ready_timeout", 32'(nfc_cmd_ready), 32'(1));
      return;
    end
    card_uid = uid; nfc_cmd_write = wr; nfc_cmd_addr = addr; nfc_cmd_wdata = wd;
    nfc_cmd_valid = 1'b1;
    tick();
    nfc_cmd_valid = 1'b0;
    model_cmd(wr, addr, wd, uid);
    chk("ready_drop", 32'(nfc_cmd_ready), 32'(0));
  endtask

  task automatic do_cmd(input string tag, input bit wr, input logic [5:0] addr,
                        input logic [7:0] wd, input logic [31:0] uid, input bit poke_busy);
    bit ok;
    int first = -1, perr_n = 0, perr_done = 0, n;
    issue(wr, addr, wd, uid, ok);
    if (!ok) return;
    n = exp_q.size();
    got_q.delete();
    for (int k = 1; k <= L + 6; k++) begin
      tick();
      if (nfc_cmd_done) begin
        if (first < 0) first = k;
        got_q.push_back(nfc_cmd_rdata);
      end
      if (proto_error) perr_n++;
      if (proto_error && nfc_cmd_done) perr_done++;
      if (k == L + n - 1) chk({tag, "_busy"}, 32'(nfc_cmd_ready), 32'(0));
      if (k == L + n)     chk({tag, "_ready"}, 32'(nfc_cmd_ready), 32'(1));
      // a strobe while busy must be dropped, not queued
      if (poke_busy && k == 2) begin
        nfc_cmd_write = 1'b1; nfc_cmd_addr = 6'h09; nfc_cmd_wdata = 8'h26;
        nfc_cmd_valid = 1'b1;
      end
      if (poke_busy && k == 3) nfc_cmd_valid = 1'b0;
    end
    chk({tag, "_ndone"}, 32'(got_q.size()), 32'(n));
    chk({tag, "_lat"}, 32'(first), 32'(L));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_perr"}, 32'(perr_n), 32'(exp_err));
    chk({tag, "_perr_done"}, 32'(perr_done), 32'(exp_err));
    check_state(tag);
  endtask

  // ANTICOLL cut short by card removal after two UID bytes.
  task automatic abort_uid(input logic [31:0] uid);
    bit ok;
    int seen = 0, extra = 0;
    bit dropped = 1'b0;
    issue(1'b1, 6'h09, 8'h93, uid, ok);
    if (!ok) return;
    for (int k = 1; k <= L + 8; k++) begin
      tick();
      if (nfc_cmd_done) begin
        if (dropped) extra++;
        else begin
          chk($sformatf("abort_b%0d", seen), 32'(nfc_cmd_rdata), 32'(exp_q[seen]));
          seen++;
        end
      end
      if (!dropped && seen == 2) begin
        card_present = 1'b0;
        dropped = 1'b1;
      end
    end
    m_st = ST_OFF; m_irq = 1'b0; m_ac = 1'b0;
    chk("abort_seen", 32'(seen), 32'(2));
    chk("abort_extra", 32'(extra), 32'(0));
    chk("abort_ready", 32'(nfc_cmd_ready), 32'(0));
    check_state("abort");
  endtask

  initial begin
    int r;
    bit wr;
    logic [5:0] addr;
    logic [7:0] wd;

    #12;
    chk("rst_ready", 32'(nfc_cmd_ready), 32'(0));
    chk("rst_done", 32'(nfc_cmd_done), 32'(0));
    chk("rst_rdata", 32'(nfc_cmd_rdata), 32'(0));
    chk("rst_perr", 32'(proto_error), 32'(0));
    check_state("rst");
    rst_n = 1'b1;
    tick(); tick();
    check_state("post_rst");

    present_on();
    do_cmd("reqa", 1'b1, 6'h09, 8'h26, 32'h0, 1'b0);
    do_cmd("anticoll", 1'b1, 6'h09, 8'h93, 32'hDEADBEEF, 1'b0);
    chk("bcc_const", 32'(got_q.size() == 5 ? got_q[4] : 8'hxx), 32'h22);
    do_cmd("select", 1'b1, 6'h09, 8'h93, 32'h0, 1'b0);
    do_cmd("halt", 1'b1, 6'h09, 8'h50, 32'h0, 1'b0);
    do_cmd("reqa_in_halt", 1'b1, 6'h09, 8'h26, 32'h0, 1'b0);
    do_cmd("wupa", 1'b1, 6'h09, 8'h52, 32'h0, 1'b0);
    present_off();
    present_on();
    do_cmd("sel_idle", 1'b1, 6'h09, 8'h93, 32'h0, 1'b0);
    do_cmd("read", 1'b0, 6'h01, 8'h00, 32'h0, 1'b1);
    do_cmd("wupa2", 1'b1, 6'h09, 8'h52, 32'h0, 1'b0);
    abort_uid(32'h12345678);

    for (int it = 0; it < 60; it++) begin
      if (m_st == ST_OFF) present_on();
      else if ($urandom_range(0, 11) == 0) begin
        present_off();
        present_on();
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    wd = 8'h26;
        2, 3:    wd = 8'h52;
        4, 5, 6: wd = 8'h93;
        7:       wd = 8'h50;
        default: wd = 8'($urandom);
      endcase
      wr   = ($urandom_range(0, 7) != 0);
      addr = ($urandom_range(0, 7) != 0) ? 6'h09 : 6'($urandom);
      do_cmd($sformatf("rnd%0d", it), wr, addr, wd, $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nfc_card_emulator.md
# nfc_card_emulator

ISO14443A-style PICC responder that sits on the target side of the MFRC522-style register command bus (`nfc_cmd_*`). It answers REQA/WUPA/ANTICOLL/SELECT/HALT writes with ATQA, UID+BCC and SAK byte streams, and raises `nfc_irq` on card arrival. It serves as the in-system loopback target and the simulation card model for the card-detection front end.

## Interface
Parameters:
- RESP_LATENCY, 8, cycles from command accept to first `nfc_cmd_done`; must be ≥ 1.
- ATQA, 16'h0004, answer to REQA/WUPA; sent MSB byte first.
- SAK, 8'h08, answer to SELECT; bit 2 = 0, meaning UID complete.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; the block uses one clock only.
- card_present  in  1  card in field; synchronous to clk.
- card_uid  in  32  4-byte UID, byte 3 transmitted first.
- nfc_cmd_valid  in  1  command strobe.
- nfc_cmd_ready  out  1  emulator can accept a command.
- nfc_cmd_write  in  1  1 = write, 0 = read.
- nfc_cmd_addr  in  6  register address; 6'h09 is the command register.
- nfc_cmd_wdata  in  8  command byte.
- nfc_cmd_rdata  out  8  response byte, valid only while done is high.
- nfc_cmd_done  out  1  one-cycle strobe per response byte.
- nfc_irq  out  1  card-arrival interrupt, level.
- card_state  out  3  current PICC state (encoding from package).
- proto_error  out  1  one-cycle strobe on an illegal command.

## Operation
- PICC states: OFF, IDLE, READY, ACTIVE, HALT.
- Internal flag `anticoll_done` is cleared on every entry to READY.
- Command accept: `nfc_cmd_valid && nfc_cmd_ready`.
- Commands are writes to 6'h09, decoded by `wdata`:
  - 8'h26 REQA, legal in IDLE/READY/ACTIVE: respond ATQA[15:8], ATQA[7:0]; go READY.
  - 8'h52 WUPA, legal in IDLE/READY/ACTIVE/HALT: same response; go READY.
  - 8'h93 in READY with `!anticoll_done` (ANTICOLL): respond uid[31:24], uid[23:16], uid[15:8], uid[7:0], BCC.
    - BCC = XOR of the four UID bytes.
    - `card_uid` is sampled at accept.
    - Set `anticoll_done`.
  - 8'h93 in READY with `anticoll_done` (SELECT): respond SAK; go ACTIVE.
  - 8'h50 HALT in ACTIVE: respond 8'h00; go HALT.
- Illegal command, either an unknown byte or a legal byte in the wrong state:
  - respond one byte 8'h00;
  - pulse `proto_error` with the done strobe;
  - go IDLE (HALT stays HALT).
- Any command while OFF: no acceptance, because ready is low in OFF.
- Non-command accesses: a write to any other address, or any read, returns one done with rdata 8'h00 and no state change.
- IRQ:
  - `card_present` rising edge: OFF→IDLE; `nfc_irq` goes high one cycle later.
  - `nfc_irq` clears on the accept of a REQA or WUPA.
- `card_present` falling edge:
  - immediate abort;
  - any pending response is discarded, with no further done;
  - state OFF; `nfc_irq` = 0; `anticoll_done` = 0.

## Timing
- Reset values:
  - ready = 0; done = 0; rdata = 8'h00; irq = 0; proto_error = 0;
  - card_state = OFF;
  - latency counter = 0; byte index = 0.
- `nfc_cmd_ready` is high exactly when state ≠ OFF and no response is pending. It drops the cycle after accept.
- Response sequencing:
  - after accept, wait RESP_LATENCY cycles;
  - emit N done pulses on N consecutive cycles;
  - `rdata` is registered with each pulse.
- ready rises the cycle after the last done, so the back-to-back accept period is RESP_LATENCY+N+1.
- State change commits on the cycle of the last done, not at accept.
- Illegal command: `proto_error` is coincident with its single done.
- Counters:
  - latency counter width is `$clog2(RESP_LATENCY+1)`;
  - byte index is 3 bits, with N ≤ 5;
  - no wrap is possible.
- Simultaneous presence fall and last done: abort wins; done is suppressed.
- `valid` while ready = 0: ignored, not queued.

## Structure
- Shared package `nfc_pkg` holds:
  - CMD_REQA, CMD_WUPA, CMD_SEL_CL1, CMD_HALT, ADDR_CMD = 6'h09;
  - enum `picc_state_t` (3-bit);
  - ATQA_MIFARE.
- The card-detection front end imports the same constants from `nfc_pkg`.
- Single module; no sub-module. The response byte mux is a case on byte index.

## Test plan
- Presence rise: irq high 1 cycle later; REQA accepted → done bytes 8'h00, 8'h04 at accept+8 and +9; irq 0; state READY.
- Full select flow with uid 32'hDEADBEEF:
  - ANTICOLL → DE, AD, BE, EF, 22 (BCC);
  - SELECT → 08; state ACTIVE.
- HALT in ACTIVE → done 00, state HALT; REQA → proto_error, no state change; WUPA → ATQA, state READY.
- SELECT issued in IDLE → single done 00 with proto_error=1; state IDLE.
- card_present falls mid-UID after 2 bytes → no further done, state OFF, ready low, irq 0.
- Read of addr 6'h01 in IDLE → one done, rdata 00, state unchanged; valid during busy ignored.
